// File: rtl/led_pwm_driver.sv
//============================================================================
// Module  : led_pwm_driver
// Brief   : Period-synchronous PWM dimming and blink stage for 8 LED pins.
//           Define LED_PWM_GAMMA_EN to square the duty value (gamma mapping).
// Revision: 1.0  initial release
//============================================================================
`default_nettype none

module led_pwm_driver #(
  parameter int PRESCALE      = 195,
  parameter int PWM_BITS      = 8,
  parameter int BLINK_PERIODS = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          led_i,
  input  logic [7:0]          blink_en_i,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic [7:0]          led_o,
  output logic                period_tick_o
);

  localparam logic [15:0]         PRESC_MAX = 16'(PRESCALE - 1);
  localparam logic [15:0]         BLINK_MAX = 16'(BLINK_PERIODS - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;

  logic [15:0]         presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [15:0]         blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic                start_pend_q, start_pend_d;
  logic [7:0]          led_sh_q, led_sh_d;
  logic [7:0]          blink_sh_q, blink_sh_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [7:0]          led_out_q, led_out_d;
  logic                tick_q, tick_d;

  logic                step;
  logic                ps;
  logic                pwm_on;
  logic [PWM_BITS-1:0] duty_eff;

`ifdef LED_PWM_GAMMA_EN
  logic [2*PWM_BITS-1:0] duty_ext;
  logic [2*PWM_BITS-1:0] duty_sq;
  assign duty_ext = {{PWM_BITS{1'b0}}, duty_q};
  assign duty_sq  = duty_ext * duty_ext;
  assign duty_eff = duty_sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign duty_eff = duty_q;
`endif

  assign step   = (presc_q == PRESC_MAX);
  assign ps     = start_pend_q | (step & (pwm_q == PWM_MAX));
  // Full-scale duty bypasses the compare so there is no one-step dark gap.
  assign pwm_on = (duty_q == PWM_MAX) | (pwm_q < duty_eff);

  always_comb begin
    presc_d      = step ? 16'd0 : presc_q + 16'd1;
    pwm_d        = step ? pwm_q + 1'b1 : pwm_q;
    start_pend_d = 1'b0;
    blink_cnt_d  = blink_cnt_q;
    phase_d      = phase_q;
    led_sh_d     = led_sh_q;
    blink_sh_d   = blink_sh_q;
    duty_d       = duty_q;
    tick_d       = ps;
    led_out_d    = led_sh_q & {8{pwm_on}} & (~blink_sh_q | {8{phase_q}});

    if (ps) begin
      led_sh_d   = led_i;
      blink_sh_d = blink_en_i;
      duty_d     = duty_i;
      if (!start_pend_q) begin
        if (blink_cnt_q == BLINK_MAX) begin
          blink_cnt_d = 16'd0;
          phase_d     = ~phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= 16'd0;
      pwm_q        <= '0;
      blink_cnt_q  <= 16'd0;
      phase_q      <= 1'b1;
      start_pend_q <= 1'b1;
      led_sh_q     <= 8'd0;
      blink_sh_q   <= 8'd0;
      duty_q       <= '1;
      led_out_q    <= 8'd0;
      tick_q       <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      pwm_q        <= pwm_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      start_pend_q <= start_pend_d;
      led_sh_q     <= led_sh_d;
      blink_sh_q   <= blink_sh_d;
      duty_q       <= duty_d;
      led_out_q    <= led_out_d;
      tick_q       <= tick_d;
    end
  end

  assign led_o         = led_out_q;
  assign period_tick_o = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_led_pwm_driver.sv
//============================================================================
// Module  : tb_led_pwm_driver
// Brief   : Directed self-checking bench for led_pwm_driver (PRESCALE=1,
//           BLINK_PERIODS=2). k counts clock edges since reset release.
// Revision: 1.0  initial release
//============================================================================
`default_nettype none

module tb_led_pwm_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] led_i;
  logic [7:0] blink_en_i;
  logic [7:0] duty_i;
  logic [7:0] led_o;
  logic       period_tick_o;

  int k = 0;
  int checks = 0;
  int errors = 0;

  led_pwm_driver #(
    .PRESCALE     (1),
    .PWM_BITS     (8),
    .BLINK_PERIODS(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .led_i        (led_i),
    .blink_en_i   (blink_en_i),
    .duty_i       (duty_i),
    .led_o        (led_o),
    .period_tick_o(period_tick_o)
  );

  always #5 clk = ~clk;

  // After edge k (k=0 is the first edge with rst low) led_o reflects PWM step k%256.
  always @(posedge clk) begin
    if (rst) k <= -1;
    else     k <= k + 1;
  end

  function automatic logic [7:0] exp_led(input int kk, input logic [7:0] led,
                                         input logic [7:0] duty, input logic [7:0] blink,
                                         input logic phase);
    logic on;
    on = (duty == 8'hFF) || ((kk % 256) < int'(duty));
    return led & {8{on}} & (~blink | {8{phase}});
  endfunction

  task automatic do_reset(input logic [7:0] led, input logic [7:0] duty, input logic [7:0] blink);
    @(negedge clk);
    rst = 1'b1; led_i = led; duty_i = duty; blink_en_i = blink;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; led_i = 8'hFF; duty_i = 8'h40; blink_en_i = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (led_o !== 8'h00) begin
        errors++; $display("FAIL reset_led cycle %0d actual=%h expected=00", i, led_o);
      end
      checks++;
      if (period_tick_o !== 1'b0) begin
        errors++; $display("FAIL reset_tick cycle %0d actual=%b expected=0", i, period_tick_o);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (period_tick_o !== 1'b1) begin
      errors++; $display("FAIL release_tick actual=%b expected=1", period_tick_o);
    end
    checks++;
    if (led_o !== 8'h00) begin
      errors++; $display("FAIL release_led actual=%h expected=00", led_o);
    end
    @(negedge clk);
    checks++;
    if (led_o !== 8'hFF) begin
      errors++; $display("FAIL first_on_led actual=%h expected=FF", led_o);
    end
    checks++;
    if (period_tick_o !== 1'b0) begin
      errors++; $display("FAIL first_on_tick actual=%b expected=0", period_tick_o);
    end
  endtask

  task automatic test_pwm_basic();
    int bad = 0, tbad = 0, hi = 0, bk = 0;
    logic [7:0] exp, bact = 8'h00, bexp = 8'h00;
    do_reset(8'hFF, 8'h40, 8'h00);
    while (k < 767) begin
      @(negedge clk);
      exp = exp_led(k, 8'hFF, 8'h40, 8'h00, 1'b1);
      if (led_o !== exp) begin
        if (bad == 0) begin bk = k; bact = led_o; bexp = exp; end
        bad++;
      end
      if (period_tick_o !== ((k % 256) == 255)) tbad++;
      if (k >= 256 && k < 512 && led_o == 8'hFF) hi++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL pwm40_pattern %0d bad cycles, first k=%0d actual=%h expected=%h", bad, bk, bact, bexp);
    end
    checks++;
    if (tbad != 0) begin
      errors++; $display("FAIL pwm40_tick actual=%0d misplaced ticks expected=0", tbad);
    end
    checks++;
    if (hi != 64) begin
      errors++; $display("FAIL pwm40_hightime actual=%0d expected=64", hi);
    end
  endtask

  task automatic test_duty_extremes();
    int bad = 0, full = 0, bk = 0;
    logic [7:0] exp, bact = 8'h00, bexp = 8'h00;
    do_reset(8'h0F, 8'h00, 8'h00);
    while (k < 767) begin
      @(negedge clk);
      exp = (k >= 512) ? 8'h0F : 8'h00;
      if (led_o !== exp) begin
        if (bad == 0) begin bk = k; bact = led_o; bexp = exp; end
        bad++;
      end
      if (k >= 512 && led_o == 8'h0F) full++;
      if (k == 300) duty_i = 8'hFF;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL duty_extremes %0d bad cycles, first k=%0d actual=%h expected=%h", bad, bk, bact, bexp);
    end
    checks++;
    if (full != 256) begin
      errors++; $display("FAIL duty_ff_nogap actual=%0d expected=256", full);
    end
  endtask

  task automatic test_mid_period();
    int bad = 0, hi_a = 0, hi_b = 0, bk = 0;
    logic [7:0] exp, bact = 8'h00, bexp = 8'h00;
    do_reset(8'h0F, 8'h40, 8'h00);
    while (k < 767) begin
      @(negedge clk);
      exp = (k < 512) ? exp_led(k, 8'h0F, 8'h40, 8'h00, 1'b1)
                      : exp_led(k, 8'hF0, 8'h80, 8'h00, 1'b1);
      if (led_o !== exp) begin
        if (bad == 0) begin bk = k; bact = led_o; bexp = exp; end
        bad++;
      end
      if (k >= 256 && k < 512 && led_o == 8'h0F) hi_a++;
      if (k >= 512 && led_o == 8'hF0) hi_b++;
      if (k == 265) begin led_i = 8'hF0; duty_i = 8'h80; end
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL mid_period %0d bad cycles, first k=%0d actual=%h expected=%h", bad, bk, bact, bexp);
    end
    checks++;
    if (hi_a != 64) begin
      errors++; $display("FAIL mid_period_old_high actual=%0d expected=64", hi_a);
    end
    checks++;
    if (hi_b != 128) begin
      errors++; $display("FAIL mid_period_new_high actual=%0d expected=128", hi_b);
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0, bk = 0;
    logic [7:0] exp, bact = 8'h00, bexp = 8'h00;
    do_reset(8'hFF, 8'h10, 8'h00);
    while (k < 767) begin
      @(negedge clk);
      if (k < 256)      exp = exp_led(k, 8'hFF, 8'h10, 8'h00, 1'b1);
      else if (k < 512) exp = exp_led(k, 8'hAA, 8'h20, 8'h00, 1'b1);
      else              exp = exp_led(k, 8'h55, 8'hF0, 8'h00, 1'b1);
      if (led_o !== exp) begin
        if (bad == 0) begin bk = k; bact = led_o; bexp = exp; end
        bad++;
      end
      if (k == 100) begin led_i = 8'hAA; duty_i = 8'h20; end
      if (k == 300) begin led_i = 8'h55; duty_i = 8'hF0; end
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL back_to_back %0d bad cycles, first k=%0d actual=%h expected=%h", bad, bk, bact, bexp);
    end
  endtask

  task automatic test_blink();
    int bad = 0, low0 = 0, bk = 0, m;
    logic ph;
    logic [7:0] exp, bact = 8'h00, bexp = 8'h00;
    do_reset(8'h03, 8'hFF, 8'h01);
    while (k < 1279) begin
      @(negedge clk);
      m   = k / 256;
      ph  = ((m / 2) % 2) == 0;
      exp = exp_led(k, 8'h03, 8'hFF, 8'h01, ph);
      if (led_o !== exp) begin
        if (bad == 0) begin bk = k; bact = led_o; bexp = exp; end
        bad++;
      end
      if (led_o[0] == 1'b0) low0++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL blink %0d bad cycles, first k=%0d actual=%h expected=%h", bad, bk, bact, bexp);
    end
    checks++;
    if (low0 != 512) begin
      errors++; $display("FAIL blink_off_time actual=%0d expected=512", low0);
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0, hi = 0, bk = 0;
    logic [7:0] exp, bact = 8'h00, bexp = 8'h00;
    do_reset(8'hFF, 8'h80, 8'h00);
    while (k < 355) @(negedge clk);
    checks++;
    if (led_o !== 8'hFF) begin
      errors++; $display("FAIL pre_reset_led actual=%h expected=FF", led_o);
    end
    rst = 1'b1; led_i = 8'h3C; duty_i = 8'h20;
    @(negedge clk);
    checks++;
    if (led_o !== 8'h00) begin
      errors++; $display("FAIL midreset_led actual=%h expected=00", led_o);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (period_tick_o !== 1'b1) begin
      errors++; $display("FAIL midreset_release_tick actual=%b expected=1", period_tick_o);
    end
    while (k < 255) begin
      @(negedge clk);
      exp = exp_led(k, 8'h3C, 8'h20, 8'h00, 1'b1);
      if (led_o !== exp || period_tick_o !== (k == 255)) begin
        if (bad == 0) begin bk = k; bact = led_o; bexp = exp; end
        bad++;
      end
      if (led_o == 8'h3C) hi++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL midreset_restart %0d bad cycles, first k=%0d actual=%h expected=%h", bad, bk, bact, bexp);
    end
    checks++;
    if (hi != 31) begin
      errors++; $display("FAIL midreset_first_period_high actual=%0d expected=31", hi);
    end
  endtask

  task automatic test_gamma();
    int hi = 0, want;
`ifdef LED_PWM_GAMMA_EN
    want = 64;
`else
    want = 128;
`endif
    do_reset(8'h01, 8'h80, 8'h00);
    while (k < 511) begin
      @(negedge clk);
      if (k >= 256 && led_o[0] == 1'b1) hi++;
    end
    checks++;
    if (hi != want) begin
      errors++; $display("FAIL gamma_high_time actual=%0d expected=%0d", hi, want);
    end
  endtask

  initial begin
    rst = 1'b1; led_i = 8'h00; blink_en_i = 8'h00; duty_i = 8'h00;
    test_reset();
    test_pwm_basic();
    test_duty_extremes();
    test_mid_period();
    test_back_to_back();
    test_blink();
    test_reset_mid();
    test_gamma();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
